// File: rtl/udp_rx_perf_checker_pkg.sv
// Shared types and helpers for the UDP receive performance checker:
// run state encoding, latched run configuration, saturating counter step,
// and the packet-geometry math (beats per packet, bytes in the last beat).
package udp_rx_perf_checker_pkg;

   localparam int          LANE_W  = 32;
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RECV  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Configuration captured when a run is armed.
   typedef struct packed {
      logic [31:0] pkt_num;     // packets expected in the run
      logic [31:0] bpp;         // beats per packet (always >= 1)
      logic [31:0] last_bytes;  // valid bytes in the last beat (1..keep width)
   } run_cfg_t;

   // Counter step that sticks at all-ones instead of wrapping.
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      logic [31:0] r;
      if (v == CNT_MAX) begin
         r = v;
      end else begin
         r = v + 32'd1;
      end
      return r;
   endfunction

   // A zero-byte packet is treated as one byte long.
   function automatic logic [31:0] eff_size(input logic [31:0] size);
      logic [31:0] r;
      if (size == 32'd0) begin
         r = 32'd1;
      end else begin
         r = size;
      end
      return r;
   endfunction

   // ceil(size / keep_w), computed without the 32-bit overflow of (size + keep_w - 1).
   function automatic logic [31:0] calc_bpp(input logic [31:0] size, input logic [31:0] keep_w);
      logic [31:0] s;
      logic [31:0] r;
      s = eff_size(size);
      if ((s % keep_w) != 32'd0) begin
         r = (s / keep_w) + 32'd1;
      end else begin
         r = s / keep_w;
      end
      return r;
   endfunction

   // Number of bytes the last beat carries; a full beat when size divides evenly.
   function automatic logic [31:0] calc_last_bytes(input logic [31:0] size, input logic [31:0] keep_w);
      logic [31:0] rem;
      logic [31:0] r;
      rem = eff_size(size) % keep_w;
      if (rem == 32'd0) begin
         r = keep_w;
      end else begin
         r = rem;
      end
      return r;
   endfunction

endpackage

// File: rtl/udp_rx_beat_checker.sv
// Combinational compare of one received beat against the generator pattern:
// every 32-bit lane of beat n carries n. Only bytes enabled by tkeep are
// compared for data; the keep vector itself is compared in full.
module udp_rx_beat_checker
   import udp_rx_perf_checker_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
   input  logic [DATA_WIDTH-1:0] tdata_i,
   input  logic [KEEP_WIDTH-1:0] tkeep_i,
   input  logic [KEEP_WIDTH-1:0] exp_keep_i,
   input  logic [31:0]           seq_i,
   output logic                  data_err_o,
   output logic                  keep_err_o
);

   localparam int LANE_BYTES = LANE_W / 8;

   logic [KEEP_WIDTH-1:0] byte_err_s;

   // Byte i sits in lane i/4 at byte position i%4 of that lane.
   for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_byte
      assign byte_err_s[i] = tkeep_i[i] &
                             (tdata_i[i*8 +: 8] != seq_i[(i % LANE_BYTES)*8 +: 8]);
   end

   // Reduce per-byte mismatches and compare keep against the expected shape.
   always_comb begin
      data_err_o = |byte_err_s;
      keep_err_o = (tkeep_i != exp_keep_i);
   end

endmodule

// File: rtl/udp_rx_perf_checker.sv
// Receive-side perf/integrity checker for the UDP loopback path. Checks each
// accepted beat against the deterministic payload pattern, tracks packet
// framing against the configured size, and counts cycles, beats, packets and
// errors for one armed run. All status outputs are registered.
module udp_rx_perf_checker
   import udp_rx_perf_checker_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int KEEP_WIDTH = DATA_WIDTH/8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rx_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] rx_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] rx_axis_tkeep,
   input  logic                  rx_axis_tlast,
   input  logic                  rx_axis_tuser,
   output logic                  rx_axis_tready,
   input  logic                  start,
   input  logic [31:0]           pkt_size,
   input  logic [31:0]           pkt_num,
   output logic                  recv_enable,
   output logic                  is_first_frame,
   output logic [31:0]           perf_cycles,
   output logic [31:0]           beat_count,
   output logic [31:0]           pkt_count,
   output logic [31:0]           err_beat_count,
   output logic [31:0]           err_len_count,
   output logic                  done
);

   localparam logic [31:0] KEEP_W32 = 32'(KEEP_WIDTH);

   state_e      state_q, state_d;
   run_cfg_t    cfg_q, cfg_d;
   logic [31:0] seq_q, seq_d;
   logic [31:0] idx_q, idx_d;
   logic        len_flag_q, len_flag_d;
   logic [31:0] beat_cnt_q, beat_cnt_d;
   logic [31:0] pkt_cnt_q, pkt_cnt_d;
   logic [31:0] err_beat_q, err_beat_d;
   logic [31:0] err_len_q, err_len_d;
   logic [31:0] perf_q, perf_d;
   logic        done_q, done_d;
   logic        recv_en_q, recv_en_d;
   logic        first_q, first_d;
   logic        tready_q;

   logic                  accept_s;
   logic                  is_last_idx_s;
   logic [KEEP_WIDTH-1:0] last_keep_s;
   logic [KEEP_WIDTH-1:0] exp_keep_s;
   logic                  data_err_s;
   logic                  keep_err_s;
   logic                  beat_err_s;
   logic                  unused_tuser;

   // tuser carries nothing this checker cares about.
   assign unused_tuser = rx_axis_tuser;

   assign accept_s      = rx_axis_tvalid & tready_q;
   assign is_last_idx_s = (idx_q == (cfg_q.bpp - 32'd1));

   // Last-beat keep: the low last_bytes bits set, contiguous from byte 0.
   for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_last_keep
      assign last_keep_s[i] = (32'(i) < cfg_q.last_bytes);
   end

   // Expected keep for the current in-packet position.
   always_comb begin
      if (is_last_idx_s) begin
         exp_keep_s = last_keep_s;
      end else begin
         exp_keep_s = {KEEP_WIDTH{1'b1}};
      end
   end

   udp_rx_beat_checker #(
      .DATA_WIDTH (DATA_WIDTH),
      .KEEP_WIDTH (KEEP_WIDTH)
   ) u_beat_checker (
      .tdata_i    (rx_axis_tdata),
      .tkeep_i    (rx_axis_tkeep),
      .exp_keep_i (exp_keep_s),
      .seq_i      (seq_q),
      .data_err_o (data_err_s),
      .keep_err_o (keep_err_s)
   );

   assign beat_err_s = data_err_s | keep_err_s;

   // Next-state, configuration latch and counter updates for the run FSM.
   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      seq_d      = seq_q;
      idx_d      = idx_q;
      len_flag_d = len_flag_q;
      beat_cnt_d = beat_cnt_q;
      pkt_cnt_d  = pkt_cnt_q;
      err_beat_d = err_beat_q;
      err_len_d  = err_len_q;
      perf_d     = perf_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            // Beats seen here are discarded; only start matters.
            if (start) begin
               cfg_d.pkt_num    = pkt_num;
               cfg_d.bpp        = calc_bpp(pkt_size, KEEP_W32);
               cfg_d.last_bytes = calc_last_bytes(pkt_size, KEEP_W32);
               seq_d      = 32'd0;
               idx_d      = 32'd0;
               len_flag_d = 1'b0;
               beat_cnt_d = 32'd0;
               pkt_cnt_d  = 32'd0;
               err_beat_d = 32'd0;
               err_len_d  = 32'd0;
               perf_d     = 32'd0;
               if (pkt_num == 32'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ARMED;
               end
            end else begin
               state_d = state_q;
            end
         end

         ST_ARMED, ST_RECV: begin
            // The cycle clock runs every cycle once the first beat is in.
            if (state_q == ST_RECV) begin
               perf_d = sat_inc(perf_q);
            end else begin
               perf_d = perf_q;
            end

            if (accept_s) begin
               if (state_q == ST_ARMED) begin
                  perf_d = 32'd1;
               end else begin
                  perf_d = sat_inc(perf_q);
               end
               beat_cnt_d = sat_inc(beat_cnt_q);
               if (beat_err_s) begin
                  err_beat_d = sat_inc(err_beat_q);
               end else begin
                  err_beat_d = err_beat_q;
               end
               seq_d = seq_q + 32'd1;

               if (rx_axis_tlast) begin
                  // tlast always closes the packet, early or late.
                  pkt_cnt_d  = sat_inc(pkt_cnt_q);
                  idx_d      = 32'd0;
                  len_flag_d = 1'b0;
                  if (!is_last_idx_s && !len_flag_q) begin
                     err_len_d = sat_inc(err_len_q);
                  end else begin
                     err_len_d = err_len_q;
                  end
                  if (pkt_cnt_d == cfg_q.pkt_num) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_RECV;
                  end
               end else begin
                  // Missing tlast at the expected last beat: flag once, keep counting.
                  idx_d = sat_inc(idx_q);
                  if (is_last_idx_s && !len_flag_q) begin
                     len_flag_d = 1'b1;
                     err_len_d  = sat_inc(err_len_q);
                  end else begin
                     len_flag_d = len_flag_q;
                     err_len_d  = err_len_q;
                  end
                  state_d = ST_RECV;
               end
            end else begin
               state_d = state_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered state decodes, aligned with the state register.
   always_comb begin
      done_d    = (state_d == ST_DONE);
      recv_en_d = (state_d == ST_ARMED) || (state_d == ST_RECV);
      first_d   = (state_d == ST_ARMED);
   end

   // State, configuration and counter registers; reset drops any pending update.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         cfg_q      <= '{pkt_num: 32'd0, bpp: 32'd1, last_bytes: KEEP_W32};
         seq_q      <= 32'd0;
         idx_q      <= 32'd0;
         len_flag_q <= 1'b0;
         beat_cnt_q <= 32'd0;
         pkt_cnt_q  <= 32'd0;
         err_beat_q <= 32'd0;
         err_len_q  <= 32'd0;
         perf_q     <= 32'd0;
         done_q     <= 1'b0;
         recv_en_q  <= 1'b0;
         first_q    <= 1'b0;
         tready_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         seq_q      <= seq_d;
         idx_q      <= idx_d;
         len_flag_q <= len_flag_d;
         beat_cnt_q <= beat_cnt_d;
         pkt_cnt_q  <= pkt_cnt_d;
         err_beat_q <= err_beat_d;
         err_len_q  <= err_len_d;
         perf_q     <= perf_d;
         done_q     <= done_d;
         recv_en_q  <= recv_en_d;
         first_q    <= first_d;
         tready_q   <= 1'b1;
      end
   end

   assign rx_axis_tready = tready_q;
   assign recv_enable    = recv_en_q;
   assign is_first_frame = first_q;
   assign perf_cycles    = perf_q;
   assign beat_count     = beat_cnt_q;
   assign pkt_count      = pkt_cnt_q;
   assign err_beat_count = err_beat_q;
   assign err_len_count  = err_len_q;
   assign done           = done_q;

endmodule

// File: tb/tb_udp_rx_perf_checker.sv
// Directed bench for udp_rx_perf_checker: a behavioural model pushes the
// expected status per cycle into a queue, popped and compared after the edge.
module tb_udp_rx_perf_checker;

   localparam int DW = 512;
   localparam int KW = 64;
   localparam int M_IDLE = 0, M_ARMED = 1, M_RECV = 2, M_DONE = 3;
   localparam logic [KW-1:0] ONES  = {KW{1'b1}};
   localparam logic [KW-1:0] LK100 = 64'h0000_000F_FFFF_FFFF;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          tvalid = 1'b0;
   logic [DW-1:0] tdata = '0;
   logic [KW-1:0] tkeep = '0;
   logic          tlast = 1'b0;
   logic          tuser = 1'b0;
   logic          tready;
   logic          start = 1'b0;
   logic [31:0]   pkt_size = 32'd0;
   logic [31:0]   pkt_num = 32'd0;
   logic          recv_enable, is_first_frame, done;
   logic [31:0]   perf_cycles, beat_count, pkt_count, err_beat_count, err_len_count;

   udp_rx_perf_checker dut (
      .CLK(CLK), .RST(RST),
      .rx_axis_tvalid(tvalid), .rx_axis_tdata(tdata), .rx_axis_tkeep(tkeep),
      .rx_axis_tlast(tlast), .rx_axis_tuser(tuser), .rx_axis_tready(tready),
      .start(start), .pkt_size(pkt_size), .pkt_num(pkt_num),
      .recv_enable(recv_enable), .is_first_frame(is_first_frame),
      .perf_cycles(perf_cycles), .beat_count(beat_count), .pkt_count(pkt_count),
      .err_beat_count(err_beat_count), .err_len_count(err_len_count), .done(done)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] beats, pkts, eb, el, perf;
      logic        done, recv, first;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_mis = 0;

   // Model state
   int          m_st = M_IDLE;
   logic [31:0] m_num, m_bpp, m_seq, m_idx, m_beats, m_pkts, m_eb, m_el, m_perf;
   logic [KW-1:0] m_lk;
   logic        m_flag;

   function automatic logic [DW-1:0] pat(input logic [31:0] n);
      return {16{n}};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_clear();
      m_seq = 0; m_idx = 0; m_beats = 0; m_pkts = 0; m_eb = 0; m_el = 0; m_perf = 0; m_flag = 0;
   endtask

   task automatic model_step(input logic st, input logic [31:0] sz, input logic [31:0] num,
                             input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                             input logic l);
      logic [31:0] eff, rem;
      logic        at_last, bad;
      logic [KW-1:0] ek;
      if (m_st == M_IDLE || m_st == M_DONE) begin
         if (st) begin
            eff   = (sz == 0) ? 32'd1 : sz;
            m_bpp = (eff + 32'd63) / 32'd64;
            rem   = eff % 32'd64;
            m_lk  = (rem == 0) ? ONES : ((64'd1 << rem) - 64'd1);
            m_num = num;
            model_clear();
            m_st  = (num == 0) ? M_DONE : M_ARMED;
         end
      end else begin
         if (m_st == M_RECV) m_perf++;
         if (v) begin
            if (m_st == M_ARMED) begin m_st = M_RECV; m_perf = 1; end
            m_beats++;
            at_last = (m_idx == m_bpp - 1);
            ek  = at_last ? m_lk : ONES;
            bad = (k != ek);
            for (int i = 0; i < KW; i++)
               if (k[i] && (d[i*8 +: 8] != 8'((m_seq >> ((i % 4) * 8)) & 32'hFF))) bad = 1'b1;
            if (bad) m_eb++;
            m_seq++;
            if (l) begin
               if (!at_last && !m_flag) m_el++;
               m_flag = 0; m_idx = 0; m_pkts++;
               if (m_pkts == m_num) m_st = M_DONE;
            end else begin
               if (at_last && !m_flag) begin m_el++; m_flag = 1; end
               m_idx++;
            end
         end
      end
   endtask

   // One clock: drive at negedge, push expectation, compare after the posedge.
   task automatic step(input logic st, input logic [31:0] sz, input logic [31:0] num,
                       input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic l);
      exp_t e;
      @(negedge CLK);
      start = st; pkt_size = sz; pkt_num = num;
      tvalid = v; tdata = d; tkeep = k; tlast = l;
      model_step(st, sz, num, v, d, k, l);
      e.beats = m_beats; e.pkts = m_pkts; e.eb = m_eb; e.el = m_el; e.perf = m_perf;
      e.done = (m_st == M_DONE); e.recv = (m_st == M_ARMED || m_st == M_RECV);
      e.first = (m_st == M_ARMED);
      exp_q.push_back(e);
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      chk("beat_count", beat_count, e.beats);
      chk("pkt_count", pkt_count, e.pkts);
      chk("err_beat_count", err_beat_count, e.eb);
      chk("err_len_count", err_len_count, e.el);
      chk("perf_cycles", perf_cycles, e.perf);
      chk("done", 32'(done), 32'(e.done));
      chk("recv_enable", 32'(recv_enable), 32'(e.recv));
      chk("is_first_frame", 32'(is_first_frame), 32'(e.first));
      chk("tready", 32'(tready), 32'd1);
   endtask

   task automatic go(input logic [31:0] sz, input logic [31:0] num);
      step(1'b1, sz, num, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic beat(input logic [KW-1:0] k, input logic l);
      step(1'b0, 32'd0, 32'd0, 1'b1, pat(m_seq), k, l);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_beats"}, beat_count, 32'd0);
      chk({tag, "_pkts"}, pkt_count, 32'd0);
      chk({tag, "_eb"}, err_beat_count, 32'd0);
      chk({tag, "_el"}, err_len_count, 32'd0);
      chk({tag, "_perf"}, perf_cycles, 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_recv"}, 32'(recv_enable), 32'd0);
      chk({tag, "_first"}, 32'(is_first_frame), 32'd0);
   endtask

   task automatic finals(input string tag, input logic [31:0] b, input logic [31:0] p,
                         input logic [31:0] eb, input logic [31:0] el);
      chk({tag, "_beats"}, beat_count, b);
      chk({tag, "_pkts"}, pkt_count, p);
      chk({tag, "_eb"}, err_beat_count, eb);
      chk({tag, "_el"}, err_len_count, el);
      chk({tag, "_done"}, 32'(done), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [DW-1:0] bad_d;
      m_st = M_IDLE; model_clear(); m_num = 0; m_bpp = 1; m_lk = ONES;

      // Reset state
      repeat (2) @(posedge CLK);
      #1;
      check_zero("reset");
      chk("reset_tready", 32'(tready), 32'd0);
      @(negedge CLK); RST = 1'b0;
      idle(2);

      // 128-byte packets x4, back-to-back; a beat alongside start is discarded
      step(1'b1, 32'd128, 32'd4, 1'b1, pat(32'd0), ONES, 1'b0);
      for (int i = 0; i < 8; i++) beat(ONES, (i % 2) == 1);
      finals("t1", 32'd8, 32'd4, 32'd0, 32'd0);
      chk("t1_perf", perf_cycles, 32'd8);
      idle(2);

      // 100-byte packets, correct partial last keep then all-ones last keep
      go(32'd100, 32'd2);
      beat(ONES, 1'b0); beat(LK100, 1'b1); beat(ONES, 1'b0); beat(LK100, 1'b1);
      finals("t2a", 32'd4, 32'd2, 32'd0, 32'd0);
      go(32'd100, 32'd2);
      beat(ONES, 1'b0); beat(ONES, 1'b1); beat(ONES, 1'b0); beat(ONES, 1'b1);
      finals("t2b", 32'd4, 32'd2, 32'd2, 32'd0);

      // One corrupted lane in beat 3 of a 6-beat run
      go(32'd64, 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i == 3) begin
            bad_d = pat(m_seq);
            bad_d[5*32] = ~bad_d[5*32];
            step(1'b0, 32'd0, 32'd0, 1'b1, bad_d, ONES, 1'b1);
         end else begin
            beat(ONES, 1'b1);
         end
      end
      finals("t3", 32'd6, 32'd6, 32'd1, 32'd0);

      // Early tlast: 192-byte packet ends after 2 beats
      go(32'd192, 32'd1);
      beat(ONES, 1'b0); beat(ONES, 1'b1);
      finals("t4", 32'd2, 32'd1, 32'd0, 32'd1);

      // Late tlast: 128-byte packet, tlast on beat 3, flagged once
      go(32'd128, 32'd1);
      beat(ONES, 1'b0); beat(ONES, 1'b0); beat(ONES, 1'b1);
      finals("t5", 32'd3, 32'd1, 32'd0, 32'd1);

      // Gapped beats; a start mid-run is ignored; perf frozen in DONE
      go(32'd64, 32'd3);
      beat(ONES, 1'b1); idle(1);
      step(1'b1, 32'd64, 32'd9, 1'b0, '0, '0, 1'b0);
      beat(ONES, 1'b1); idle(2);
      beat(ONES, 1'b1);
      finals("t6", 32'd3, 32'd3, 32'd0, 32'd0);
      chk("t6_perf", perf_cycles, 32'd7);
      idle(2);
      chk("t6_perf_frozen", perf_cycles, 32'd7);

      // Asynchronous reset mid-run after 5 beats
      go(32'd64, 32'd10);
      for (int i = 0; i < 5; i++) beat(ONES, 1'b1);
      @(negedge CLK);
      tvalid = 1'b1; tlast = 1'b1;
      RST = 1'b1;
      #1;
      check_zero("rst_mid");
      exp_q.delete();
      m_st = M_IDLE; model_clear();
      @(negedge CLK); RST = 1'b0; tvalid = 1'b0; tlast = 1'b0;
      idle(1);

      // Clean re-run after reset
      go(32'd64, 32'd2);
      beat(ONES, 1'b1); beat(ONES, 1'b1);
      finals("t7", 32'd2, 32'd2, 32'd0, 32'd0);

      // pkt_size 0 behaves as a one-byte packet
      go(32'd0, 32'd1);
      beat(64'h1, 1'b1);
      finals("t8", 32'd1, 32'd1, 32'd0, 32'd0);

      // pkt_num 0 completes immediately with cleared counters
      go(32'd256, 32'd0);
      finals("t9", 32'd0, 32'd0, 32'd0, 32'd0);
      chk("t9_perf", perf_cycles, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
